// File: rtl/rua_mem_pkg.sv
// Shared definitions for the rua main-RAM arbiter: default widths, port ids
// and the request bundle presented to the RAM.
package rua_mem_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 32;
  localparam int SW_DEF = DW_DEF / 8;

  // Port identifiers, also the encoding of last_grant and the response owner
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic              we;
    logic [SW_DEF-1:0] wstrb;
    logic [DW_DEF-1:0] wdata;
  } mem_req_t;

  // The port that should win a conflict, given the previous winner
  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/rua_rr_arb2.sv
// Two-way round-robin grant with the last_grant history register.
// req/gnt bit PORT_I is fetch, bit PORT_D is load/store.
module rua_rr_arb2
  import rua_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       last_grant
);

  logic       last_grant_r;
  logic [1:0] gnt_s;

  // Pick the winner; on conflict the port that did not win last time goes
  always_comb begin
    gnt_s = 2'b00;
    if (!rst) begin
      gnt_s = 2'b00;
    end else begin
      case (req)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = (other_port(last_grant_r) == PORT_D) ? 2'b10 : 2'b01;
        default: gnt_s = 2'b00;
      endcase
    end
  end

  // Remember the winner of every grant; reset makes fetch win the first conflict
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_r <= PORT_D;
    end else if (gnt_s != 2'b00) begin
      last_grant_r <= gnt_s[PORT_D];
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  assign gnt        = gnt_s;
  assign last_grant = last_grant_r;

endmodule

// File: rtl/rua_mem_arbiter.sv
// Shares the single-port rua main RAM between instruction fetch and
// load/store. One access per cycle, round-robin on conflict, and the
// one-cycle-latency read data is steered back to the issuing port.
module rua_mem_arbiter
  import rua_mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req_valid,
  output logic            i_req_ready,
  input  logic [AW-1:0]   i_req_addr,
  output logic            i_rsp_valid,
  output logic [DW-1:0]   i_rsp_data,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic [AW-1:0]   d_req_addr,
  input  logic            d_req_we,
  input  logic [DW/8-1:0] d_req_wstrb,
  input  logic [DW-1:0]   d_req_wdata,
  output logic            d_rsp_valid,
  output logic [DW-1:0]   d_rsp_data,
  output logic            mem_en,
  output logic [DW/8-1:0] mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  logic [1:0] gnt_s;
  logic       last_grant_s;
  logic       accept_s;
  mem_req_t   win_req_s;

  logic       pend_r;
  logic       owner_r;
  logic       is_wr_r;

  rua_rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        ({d_req_valid, i_req_valid}),
    .gnt        (gnt_s),
    .last_grant (last_grant_s)
  );

  // Grants only ever go to a valid requester, so a grant is an acceptance
  assign i_req_ready = gnt_s[PORT_I];
  assign d_req_ready = gnt_s[PORT_D];
  assign accept_s    = (i_req_valid & i_req_ready) | (d_req_valid & d_req_ready);

  // Build the RAM request from whichever port won this cycle
  always_comb begin
    win_req_s = '{addr: {AW{1'b0}}, we: 1'b0, wstrb: {(DW/8){1'b0}}, wdata: d_req_wdata};
    if (gnt_s[PORT_D]) begin
      win_req_s.addr  = d_req_addr;
      win_req_s.we    = d_req_we;
      win_req_s.wstrb = d_req_we ? d_req_wstrb : {(DW/8){1'b0}};
    end else begin
      win_req_s.addr  = i_req_addr;
      win_req_s.we    = 1'b0;
      win_req_s.wstrb = {(DW/8){1'b0}};
    end
  end

  assign mem_en    = accept_s;
  assign mem_addr  = win_req_s.addr;
  assign mem_we    = win_req_s.wstrb;
  assign mem_wdata = win_req_s.wdata;

  // Track who owns the RAM data coming back next cycle; reset drops it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_r  <= 1'b0;
      owner_r <= PORT_I;
      is_wr_r <= 1'b0;
    end else if (accept_s) begin
      pend_r  <= 1'b1;
      owner_r <= gnt_s[PORT_D];
      is_wr_r <= gnt_s[PORT_D] & d_req_we;
    end else begin
      pend_r  <= 1'b0;
      owner_r <= owner_r;
      is_wr_r <= is_wr_r;
    end
  end

  // Steer RAM read data to the owning port; a store acknowledge carries zero
  always_comb begin
    i_rsp_valid = 1'b0;
    i_rsp_data  = {DW{1'b0}};
    d_rsp_valid = 1'b0;
    d_rsp_data  = {DW{1'b0}};
    if (pend_r) begin
      if (owner_r == PORT_I) begin
        i_rsp_valid = 1'b1;
        i_rsp_data  = mem_rdata;
      end else begin
        d_rsp_valid = 1'b1;
        d_rsp_data  = is_wr_r ? {DW{1'b0}} : mem_rdata;
      end
    end else begin
      i_rsp_valid = 1'b0;
      d_rsp_valid = 1'b0;
    end
  end

endmodule

// File: doc/rua_mem_arbiter.md
# rua_mem_arbiter

Two-port arbiter that shares the single-port `rua` main RAM between the instruction-fetch port and the load/store port. It sits between the core pipeline and the RAM and accepts at most one access per cycle. It grants round-robin on conflict and routes the one-cycle-latency read data back to the port that issued the access. Throughput is one access per cycle with no bubbles.

## Interface
- `AW`, default 16: word-address width; the RAM holds 65536 words.
- `DW`, default 32: data width; `DW/8` byte strobes.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_req_valid`  in  1  fetch request.
- `i_req_ready`  out  1  fetch request accepted this cycle.
- `i_req_addr`  in  AW  fetch word address.
- `i_rsp_valid`  out  1  fetch data valid.
- `i_rsp_data`  out  DW  fetch data.
- `d_req_valid`  in  1  load/store request.
- `d_req_ready`  out  1  load/store request accepted this cycle.
- `d_req_addr`  in  AW  load/store word address.
- `d_req_we`  in  1  1 = store.
- `d_req_wstrb`  in  DW/8  byte enables for a store.
- `d_req_wdata`  in  DW  store data.
- `d_rsp_valid`  out  1  load data valid or store acknowledge.
- `d_rsp_data`  out  DW  load data; 0 for a store acknowledge.
- `mem_en`  out  1  RAM access strobe.
- `mem_we`  out  DW/8  RAM byte write enables.
- `mem_addr`  out  AW  RAM address.
- `mem_wdata`  out  DW  RAM write data.
- `mem_rdata`  in  DW  RAM read data, valid one cycle after `mem_en`.

## Operation
- **Grant (combinational)**
  - Only `i_req_valid` asserted: grant fetch.
  - Only `d_req_valid` asserted: grant load/store.
  - Both asserted: grant the port opposite to `last_grant`.
  - Neither asserted: no grant, `mem_en`=0.
- **Accept**
  - `x_req_ready`=1 only on the granted port. Acceptance is `valid & ready`.
  - A non-granted requester must hold address and data stable until accepted.
- **Memory drive on acceptance**
  - `mem_en`=1 and `mem_addr` taken from the winner.
  - `mem_we` = `d_req_wstrb` if it is a load/store with `d_req_we`=1, otherwise 0.
  - `mem_wdata` = `d_req_wdata`.
- **`last_grant` register** (0=fetch, 1=data)
  - Updates to the winner on every acceptance.
  - Holds when nothing is accepted.
- **Response tracking register** {`pend`, `owner`, `is_wr`}
  - Loaded on every acceptance.
  - `pend` is cleared when no acceptance occurs.
- **Response (cycle N+1 after acceptance in cycle N)**
  - `owner`=fetch: `i_rsp_valid`=1 and `i_rsp_data`=`mem_rdata`.
  - `owner`=data: `d_rsp_valid`=1 and `d_rsp_data` = `is_wr` ? 0 : `mem_rdata`.
- Requesters have no response backpressure: a response must be consumed in the cycle it appears.
- Read and write to the same address in consecutive cycles follow RAM order: a write accepted in N is visible to a read accepted in N+1 or later.
- Back-to-back acceptances pipeline, so a response and a new grant coexist in the same cycle.

## Timing
- **Reset** (`rst`=0, asynchronous)
  - Registers: `last_grant`=1, so fetch wins the first conflict; `pend`=0, `owner`=0, `is_wr`=0.
  - Outputs forced: `mem_en`=0, `mem_we`=0, both `x_req_ready`=0, both `x_rsp_valid`=0, both `x_rsp_data`=0.
- Reset asserted mid-access: the pending response is dropped and never appears after release.
- First grant is possible in the first rising edge with `rst`=1.
- Request-to-response latency is 1 cycle. With both ports streaming, each port sustains 1 access per 2 cycles.
- A single streaming port sustains 1 access per cycle.
- Fairness: a waiting requester is granted within 1 cycle of the other port's grant.

## Structure
- Shared package `rua_mem_pkg` holds:
  - `AW`/`DW` defaults;
  - port-id constants `PORT_I`=0 and `PORT_D`=1;
  - the request struct {addr, we, wstrb, wdata}.
- One sub-module, `rua_rr_arb2`: 2-way round-robin grant logic with the `last_grant` register.
- Response tracking and muxing stay in the top module.

## Test plan
- **Fetch only**
  - Stimulus: RAM[0x10]=0xDEADBEEF; `i_req_valid` with addr 0x10.
  - Required: `i_req_ready`=1 in cycle N, `i_rsp_valid`=1 with 0xDEADBEEF in N+1, `d_rsp_valid`=0 throughout.
- **Conflict after reset**
  - Stimulus: both ports valid, fetch addr 0x0, load addr 0x4.
  - Required: fetch granted in N, load in N+1; responses in N+1 (fetch) and N+2 (load).
  - Then hold both valid for 6 cycles.
  - Required: grants strictly alternate.
- **Byte store then load**
  - Stimulus: RAM[0x20]=0x11223344; store wstrb=4'b0010, wdata=0xAABBCCDD; load 0x20 next cycle.
  - Required: store ack `d_rsp_data`=0; load returns 0x1122CC44.
- **Back-to-back fetch stream**
  - Stimulus: fetch addrs 0..7 on consecutive cycles, no data requests.
  - Required: 8 consecutive `i_rsp_valid` cycles with RAM[0..7] in order.
- **Reset mid-access**
  - Stimulus: load accepted in N, `rst` low between N and N+1 edges.
  - Required: `d_rsp_valid` stays 0; after release, `last_grant`=1 behaviour (fetch wins the next conflict).
- **Idle**
  - Stimulus: no valids for 10 cycles.
  - Required: `mem_en`=0, `mem_we`=0, `last_grant` unchanged.
